// File: rtl/rv32_dispatch_decoder_pkg.sv
// Shared decode constants, type-field layouts and immediate helpers for
// the RV32I dispatch stage and the ROB/RS/LSB back end.
package rv32_dispatch_decoder_pkg;

  typedef logic [31:0] word_t;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  localparam word_t EXIT_INST = 32'hFF9FF06F;

  typedef enum logic [1:0] {
    ROB_NORMAL = 2'd0,
    ROB_BRANCH = 2'd1,
    ROB_STORE  = 2'd2,
    ROB_EXIT   = 2'd3
  } rob_type_e;

  typedef struct packed {
    logic [2:0] funct3;
    logic       alt;
    logic       is_branch;
  } rs_type_t;

  typedef struct packed {
    logic [2:0] funct3;
    logic       is_store;
  } lsb_type_t;

  function automatic word_t imm_i(word_t i);
    return {{20{i[31]}}, i[31:20]};
  endfunction

  function automatic word_t imm_b(word_t i);
    return {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
  endfunction

  function automatic word_t imm_j(word_t i);
    return {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
  endfunction

  function automatic word_t imm_u(word_t i);
    return {i[31:12], 12'h000};
  endfunction

endpackage

// File: rtl/rv32_dispatch_decoder_if.sv
// Fetch-to-decode handshake: instruction word and PC with valid/ready.
interface rv32_dispatch_decoder_if;
  import rv32_dispatch_decoder_pkg::*;

  logic  if_valid;
  logic  if_ready;
  word_t if_pc;
  word_t if_inst;

  modport master (
    output if_valid, if_pc, if_inst,
    input  if_ready
  );

  modport slave (
    input  if_valid, if_pc, if_inst,
    output if_ready
  );
endinterface

// File: rtl/rv32_dispatch_decoder_bht.sv
// dec_bht: 2-bit saturating branch counters, built only with DEC_BPRED_EN.
// Lookups are combinational and see the value before a same-edge update.
`ifdef DEC_BPRED_EN
module dec_bht #(
  parameter  int DEPTH = 64,
  localparam int IW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          rdy,
  input  logic [IW-1:0] rd_idx,
  output logic          taken,
  input  logic          upd_valid,
  input  logic          upd_taken,
  input  logic [IW-1:0] upd_idx
);
  logic [1:0] cnt [DEPTH];

  assign taken = cnt[rd_idx][1];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++)
        cnt[i] <= 2'b10;
    end else if (rdy && upd_valid) begin
      if (upd_taken && cnt[upd_idx] != 2'b11)
        cnt[upd_idx] <= cnt[upd_idx] + 2'd1;
      else if (!upd_taken && cnt[upd_idx] != 2'b00)
        cnt[upd_idx] <= cnt[upd_idx] - 2'd1;
    end
  end
endmodule
`endif

// File: rtl/rv32_dispatch_decoder.sv
// RV32I single-issue decode/dispatch stage with registered ROB/RS/LSB entry.
// DEC_BPRED_EN adds a BHT predictor; otherwise branches predict taken.
module rv32_dispatch_decoder
  import rv32_dispatch_decoder_pkg::*;
#(
  parameter int ROB_IDX_W = 4,
  parameter int BHT_DEPTH = 64
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rdy,
  input  logic                 flush,
  rv32_dispatch_decoder_if.slave fe,
  output logic                 redirect_valid,
  output logic [31:0]          redirect_pc,
  output logic [4:0]           rs1_id,
  output logic [4:0]           rs2_id,
  input  logic [31:0]          rs1_val,
  input  logic [31:0]          rs2_val,
  input  logic                 rs1_busy,
  input  logic                 rs2_busy,
  input  logic [ROB_IDX_W-1:0] rs1_tag,
  input  logic [ROB_IDX_W-1:0] rs2_tag,
  input  logic                 rob_full,
  input  logic                 rs_full,
  input  logic                 lsb_full,
  input  logic [ROB_IDX_W-1:0] rob_tail,
  output logic                 rob_valid,
  output logic                 rs_valid,
  output logic                 lsb_valid,
  output logic [1:0]           rob_type,
  output logic [4:0]           rob_rd,
  output logic [31:0]          rob_imm,
  output logic                 rob_done,
  output logic [31:0]          rob_pc,
  output logic [31:0]          rob_alt_pc,
  output logic                 rob_pred_taken,
  output logic [31:0]          op1_val,
  output logic [31:0]          op2_val,
  output logic                 op1_busy,
  output logic                 op2_busy,
  output logic [ROB_IDX_W-1:0] op1_tag,
  output logic [ROB_IDX_W-1:0] op2_tag,
  output logic [ROB_IDX_W-1:0] dst_tag,
  output logic [4:0]           rs_type,
  output logic [3:0]           lsb_type,
  output logic [11:0]          lsb_offset,
  input  logic                 bp_upd_valid,
  input  logic                 bp_upd_taken,
  input  logic [31:0]          bp_upd_pc
);
  word_t      inst, pc, pc4, br_tgt;
  logic [6:0] opc;
  logic [2:0] f3;
  logic is_op, is_opi, is_br, is_ld, is_st;
  logic is_lui, is_auipc, is_jal, is_jalr, is_exit;
  logic need_rs, need_lsb, use_rs1, use_rs2;
  logic jalr_stall, accept, pred, unused_bp;

  assign inst   = fe.if_inst;
  assign pc     = fe.if_pc;
  assign opc    = inst[6:0];
  assign f3     = inst[14:12];
  assign rs1_id = inst[19:15];
  assign rs2_id = inst[24:20];

  assign is_exit  = inst == EXIT_INST;
  assign is_op    = opc == OPC_OP;
  assign is_opi   = opc == OPC_OPIMM;
  assign is_br    = opc == OPC_BRANCH;
  assign is_ld    = opc == OPC_LOAD;
  assign is_st    = opc == OPC_STORE;
  assign is_lui   = opc == OPC_LUI;
  assign is_auipc = opc == OPC_AUIPC;
  assign is_jal   = opc == OPC_JAL && !is_exit;
  assign is_jalr  = opc == OPC_JALR;

  assign need_rs  = is_op | is_opi | is_br;
  assign need_lsb = is_ld | is_st;
  assign use_rs1  = need_rs | need_lsb;
  assign use_rs2  = is_op | is_br | is_st;

`ifdef DEC_BPRED_EN
  localparam int IDX_W = $clog2(BHT_DEPTH);

  dec_bht #(.DEPTH(BHT_DEPTH)) u_bht (
    .clk       (clk),
    .rst_n     (rst_n),
    .rdy       (rdy),
    .rd_idx    (pc[IDX_W+1:2]),
    .taken     (pred),
    .upd_valid (bp_upd_valid),
    .upd_taken (bp_upd_taken),
    .upd_idx   (bp_upd_pc[IDX_W+1:2])
  );
  assign unused_bp = ^bp_upd_pc;
`else
  assign pred      = 1'b1;
  assign unused_bp = ^{bp_upd_valid, bp_upd_taken, bp_upd_pc,
                       32'(BHT_DEPTH)};
`endif

  // JALR target needs rs1 now, so it waits until rs1 is no longer renamed.
  assign jalr_stall = is_jalr & rs1_busy & (rs1_id != 5'd0);

  assign accept = fe.if_valid & !rob_full
                & (!need_rs | !rs_full)
                & (!need_lsb | !lsb_full)
                & !jalr_stall & !flush & rdy;

  assign fe.if_ready = accept;

  assign pc4    = pc + 32'd4;
  assign br_tgt = pc + imm_b(inst);

  rob_type_e  n_type;
  logic [4:0] n_rd;
  word_t      n_imm, n_alt, n_tgt, n_op2;
  logic       n_done, n_redir, n_pred, shamt_op;
  rs_type_t   n_rs;
  lsb_type_t  n_lsb;

  always_comb begin
    n_type  = ROB_NORMAL;
    n_rd    = inst[11:7];
    n_imm   = '0;
    n_done  = 1'b0;
    n_alt   = pc4;
    n_tgt   = pc + imm_j(inst);
    n_redir = 1'b0;
    n_pred  = 1'b0;
    unique case (1'b1)
      is_exit: begin
        n_type = ROB_EXIT;
        n_rd   = '0;
        n_done = 1'b1;
      end
      is_lui: begin
        n_imm  = imm_u(inst);
        n_done = 1'b1;
      end
      is_auipc: begin
        n_imm  = pc + imm_u(inst);
        n_done = 1'b1;
      end
      is_jal: begin
        n_imm   = pc4;
        n_done  = 1'b1;
        n_redir = 1'b1;
      end
      is_jalr: begin
        n_imm   = pc4;
        n_done  = 1'b1;
        n_redir = 1'b1;
        n_tgt   = (rs1_val + imm_i(inst)) & ~32'd1;
      end
      is_br: begin
        n_type  = ROB_BRANCH;
        n_rd    = '0;
        n_pred  = pred;
        n_redir = pred;
        n_tgt   = br_tgt;
        n_alt   = pred ? pc4 : br_tgt;
      end
      is_st: begin
        n_type = ROB_STORE;
        n_rd   = '0;
      end
      is_op, is_opi, is_ld: ;
      default: begin
        n_rd   = '0;
        n_done = 1'b1;
      end
    endcase
  end

  assign shamt_op = is_opi && (f3 == 3'b001 || f3 == 3'b101);
  assign n_op2 = is_opi  ? (shamt_op ? {27'd0, inst[24:20]}
                                     : imm_i(inst))
               : use_rs2 ? rs2_val : '0;

  assign n_rs = '{funct3: f3,
                  alt: inst[30] & (is_op | (is_opi & f3 == 3'b101)),
                  is_branch: is_br};
  assign n_lsb = '{funct3: f3, is_store: is_st};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rob_valid      <= 1'b0;
      rs_valid       <= 1'b0;
      lsb_valid      <= 1'b0;
      redirect_valid <= 1'b0;
      redirect_pc    <= '0;
      rob_type       <= '0;
      rob_rd         <= '0;
      rob_imm        <= '0;
      rob_done       <= 1'b0;
      rob_pc         <= '0;
      rob_alt_pc     <= '0;
      rob_pred_taken <= 1'b0;
      op1_val        <= '0;
      op2_val        <= '0;
      op1_busy       <= 1'b0;
      op2_busy       <= 1'b0;
      op1_tag        <= '0;
      op2_tag        <= '0;
      dst_tag        <= '0;
      rs_type        <= '0;
      lsb_type       <= '0;
      lsb_offset     <= '0;
    end else if (rdy) begin
      rob_valid      <= accept;
      rs_valid       <= accept & need_rs;
      lsb_valid      <= accept & need_lsb;
      redirect_valid <= accept & n_redir;
      if (accept) begin
        redirect_pc    <= n_tgt;
        rob_type       <= n_type;
        rob_rd         <= n_rd;
        rob_imm        <= n_imm;
        rob_done       <= n_done;
        rob_pc         <= pc;
        rob_alt_pc     <= n_alt;
        rob_pred_taken <= n_pred;
        op1_val        <= use_rs1 ? rs1_val : '0;
        op2_val        <= n_op2;
        op1_busy       <= use_rs1 & rs1_busy & (rs1_id != 5'd0);
        op2_busy       <= use_rs2 & rs2_busy & (rs2_id != 5'd0);
        op1_tag        <= use_rs1 ? rs1_tag : '0;
        op2_tag        <= use_rs2 ? rs2_tag : '0;
        dst_tag        <= rob_tail;
        rs_type        <= n_rs;
        lsb_type       <= n_lsb;
        lsb_offset     <= is_st ? {inst[31:25], inst[11:7]}
                                : inst[31:20];
      end
    end
  end
endmodule

// File: tb/tb_rv32_dispatch_decoder.sv
// Bench for rv32_dispatch_decoder: directed scenarios, then random traffic
// compared against an instruction-level reference model.
module tb_rv32_dispatch_decoder;
  import rv32_dispatch_decoder_pkg::*;

  localparam int RW = 4;
  localparam int BD = 64;

  logic          clk = 1'b0;
  logic          rst_n, rdy, flush;
  logic          redirect_valid;
  logic [31:0]   redirect_pc;
  logic [4:0]    rs1_id, rs2_id;
  logic [31:0]   rs1_val, rs2_val;
  logic          rs1_busy, rs2_busy;
  logic [RW-1:0] rs1_tag, rs2_tag, rob_tail;
  logic          rob_full, rs_full, lsb_full;
  logic          rob_valid, rs_valid, lsb_valid;
  logic [1:0]    rob_type;
  logic [4:0]    rob_rd;
  logic [31:0]   rob_imm, rob_pc, rob_alt_pc;
  logic          rob_done, rob_pred_taken;
  logic [31:0]   op1_val, op2_val;
  logic          op1_busy, op2_busy;
  logic [RW-1:0] op1_tag, op2_tag, dst_tag;
  logic [4:0]    rs_type;
  logic [3:0]    lsb_type;
  logic [11:0]   lsb_offset;
  logic          bp_upd_valid, bp_upd_taken;
  logic [31:0]   bp_upd_pc;

  always #5 clk = ~clk;

  rv32_dispatch_decoder_if fe();

  rv32_dispatch_decoder #(.ROB_IDX_W(RW), .BHT_DEPTH(BD)) dut (
    .clk(clk), .rst_n(rst_n), .rdy(rdy), .flush(flush), .fe(fe),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .rs1_id(rs1_id), .rs2_id(rs2_id),
    .rs1_val(rs1_val), .rs2_val(rs2_val),
    .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
    .rs1_tag(rs1_tag), .rs2_tag(rs2_tag),
    .rob_full(rob_full), .rs_full(rs_full), .lsb_full(lsb_full),
    .rob_tail(rob_tail),
    .rob_valid(rob_valid), .rs_valid(rs_valid), .lsb_valid(lsb_valid),
    .rob_type(rob_type), .rob_rd(rob_rd), .rob_imm(rob_imm),
    .rob_done(rob_done), .rob_pc(rob_pc), .rob_alt_pc(rob_alt_pc),
    .rob_pred_taken(rob_pred_taken),
    .op1_val(op1_val), .op2_val(op2_val),
    .op1_busy(op1_busy), .op2_busy(op2_busy),
    .op1_tag(op1_tag), .op2_tag(op2_tag), .dst_tag(dst_tag),
    .rs_type(rs_type), .lsb_type(lsb_type), .lsb_offset(lsb_offset),
    .bp_upd_valid(bp_upd_valid), .bp_upd_taken(bp_upd_taken),
    .bp_upd_pc(bp_upd_pc)
  );

  typedef struct {
    logic          rob_v, rs_v, lsb_v, red_v;
    logic [31:0]   red_pc;
    logic [1:0]    rtype;
    logic [4:0]    rd;
    logic [31:0]   imm;
    logic          imm_chk, done, pt;
    logic [31:0]   pc, alt, o1, o2;
    logic          o2_chk, b1, b2;
    logic [RW-1:0] t1, t2, dt;
    logic [4:0]    rst;
    logic [3:0]    lt;
    logic [11:0]   off;
  } exp_t;

  exp_t e;
  int   n_chk = 0;
  int   n_err = 0;

`ifdef DEC_BPRED_EN
  localparam int IW = $clog2(BD);
  int bht_m [BD];
`endif

  localparam int C_OP = 0, C_OPI = 1, C_BR = 2, C_LD = 3, C_ST = 4;
  localparam int C_LUI = 5, C_AUI = 6, C_JAL = 7, C_JALR = 8;
  localparam int C_EXIT = 9, C_UNK = 10;

  task automatic check(string tag, logic [31:0] got, logic [31:0] want);
    n_chk++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, got, want);
    end
  endtask

  function automatic int cls_of(logic [31:0] i);
    if (i == 32'hFF9FF06F) return C_EXIT;
    case (i[6:0])
      7'h33:   return C_OP;
      7'h13:   return C_OPI;
      7'h63:   return C_BR;
      7'h03:   return C_LD;
      7'h23:   return C_ST;
      7'h37:   return C_LUI;
      7'h17:   return C_AUI;
      7'h6F:   return C_JAL;
      7'h67:   return C_JALR;
      default: return C_UNK;
    endcase
  endfunction

  // Next-cycle expectation from the current inputs; also steps the BHT model.
  task automatic model(output logic acc, output exp_t nx);
    logic [31:0] i, pc, ii, ib, ij, iu;
    logic        pred, need_rs, need_lsb, stall;
    logic [2:0]  f;
    int          c;
    i  = fe.if_inst;
    pc = fe.if_pc;
    f  = i[14:12];
    c  = cls_of(i);
    ii = {{20{i[31]}}, i[31:20]};
    ib = {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
    ij = {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
    iu = {i[31:12], 12'h000};
    need_rs  = c inside {C_OP, C_OPI, C_BR};
    need_lsb = c inside {C_LD, C_ST};
    stall    = c == C_JALR && rs1_busy && i[19:15] != 5'd0;
    acc = fe.if_valid && !rob_full && !(need_rs && rs_full)
       && !(need_lsb && lsb_full) && !stall && !flush && rdy;
`ifdef DEC_BPRED_EN
    pred = bht_m[pc[IW+1:2]] >= 2;
    if (!rst_n) begin
      foreach (bht_m[k]) bht_m[k] = 2;
    end else if (rdy && bp_upd_valid) begin
      if (bp_upd_taken && bht_m[bp_upd_pc[IW+1:2]] < 3)
        bht_m[bp_upd_pc[IW+1:2]]++;
      else if (!bp_upd_taken && bht_m[bp_upd_pc[IW+1:2]] > 0)
        bht_m[bp_upd_pc[IW+1:2]]--;
    end
`else
    pred = 1'b1;
`endif
    nx = e;
    if (!rst_n) begin
      nx = '{default: 0};
    end else if (rdy) begin
      nx.rob_v = acc;
      nx.rs_v  = acc && need_rs;
      nx.lsb_v = acc && need_lsb;
      nx.red_v = 1'b0;
      if (acc) begin
        nx.pc    = pc;
        nx.dt    = rob_tail;
        nx.rtype = c == C_EXIT ? 2'd3 : c == C_BR ? 2'd1
                 : c == C_ST ? 2'd2 : 2'd0;
        nx.rd    = (c inside {C_OP, C_OPI, C_LD, C_LUI, C_AUI,
                              C_JAL, C_JALR}) ? i[11:7] : 5'd0;
        nx.done  = c inside {C_LUI, C_AUI, C_JAL, C_JALR, C_UNK, C_EXIT};
        nx.imm_chk = c inside {C_LUI, C_AUI, C_JAL, C_JALR};
        nx.imm   = c == C_LUI ? iu : c == C_AUI ? pc + iu : pc + 4;
        nx.pt    = c == C_BR && pred;
        nx.red_v = c == C_JAL || c == C_JALR || (c == C_BR && pred);
        nx.red_pc = c == C_JAL  ? pc + ij
                  : c == C_JALR ? ((rs1_val + ii) & ~32'd1)
                  : pc + ib;
        nx.alt   = (c == C_BR && !pred) ? pc + ib : pc + 4;
        nx.o1    = rs1_val;
        nx.b1    = rs1_busy && i[19:15] != 5'd0;
        nx.t1    = rs1_tag;
        nx.t2    = rs2_tag;
        nx.o2_chk = c != C_LD;
        if (c == C_OPI) begin
          nx.o2 = (f == 3'd1 || f == 3'd5) ? {27'd0, i[24:20]} : ii;
          nx.b2 = 1'b0;
        end else if (c == C_LD) begin
          nx.o2 = '0;
          nx.b2 = 1'b0;
        end else begin
          nx.o2 = rs2_val;
          nx.b2 = rs2_busy && i[24:20] != 5'd0;
        end
        nx.rst = {f, (c == C_OP || (c == C_OPI && f == 3'd5)) ? i[30]
                                                              : 1'b0,
                  c == C_BR};
        nx.lt  = {f, c == C_ST};
        nx.off = c == C_ST ? {i[31:25], i[11:7]} : i[31:20];
      end
    end
  endtask

  task automatic compare();
    check("rob_valid", rob_valid, e.rob_v);
    check("rs_valid", rs_valid, e.rs_v);
    check("lsb_valid", lsb_valid, e.lsb_v);
    check("redirect_valid", redirect_valid, e.red_v);
    check("rob_type", rob_type, e.rtype);
    check("rob_rd", rob_rd, e.rd);
    check("rob_done", rob_done, e.done);
    check("rob_pc", rob_pc, e.pc);
    check("rob_alt_pc", rob_alt_pc, e.alt);
    check("rob_pred_taken", rob_pred_taken, e.pt);
    check("dst_tag", dst_tag, e.dt);
    if (e.imm_chk) check("rob_imm", rob_imm, e.imm);
    if (e.red_v) check("redirect_pc", redirect_pc, e.red_pc);
    if (e.rs_v || e.lsb_v) begin
      check("op1_val", op1_val, e.o1);
      check("op1_busy", op1_busy, e.b1);
      check("op2_busy", op2_busy, e.b2);
      if (e.b1) check("op1_tag", op1_tag, e.t1);
      if (e.b2) check("op2_tag", op2_tag, e.t2);
      if (e.o2_chk) check("op2_val", op2_val, e.o2);
    end
    if (e.rs_v) check("rs_type", rs_type, e.rst);
    if (e.lsb_v) begin
      check("lsb_type", lsb_type, e.lt);
      check("lsb_offset", lsb_offset, e.off);
    end
  endtask

  task automatic tick();
    exp_t nx;
    logic acc;
    #1;
    model(acc, nx);
    check("if_ready", fe.if_ready, acc);
    check("rs1_id", rs1_id, fe.if_inst[19:15]);
    check("rs2_id", rs2_id, fe.if_inst[24:20]);
    @(posedge clk);
    #1;
    e = nx;
    compare();
  endtask

  task automatic rand_inputs();
    logic [31:0] i;
    logic        b;
    int          k;
    k = $urandom_range(0, 10);
    i = $urandom;
    b = i[0];
    case (k)
      0, 10: begin
        i[31:25] = ((i[14:12] == 3'd0 || i[14:12] == 3'd5) && b)
                 ? 7'h20 : 7'h00;
        i[6:0] = 7'h33;
      end
      1: begin
        if (i[14:12] == 3'd1) i[31:25] = 7'h00;
        if (i[14:12] == 3'd5) i[31:25] = b ? 7'h20 : 7'h00;
        i[6:0] = 7'h13;
      end
      2: i[6:0] = 7'h63;
      3: i[6:0] = 7'h03;
      4: i[6:0] = 7'h23;
      5: i[6:0] = 7'h37;
      6: i[6:0] = 7'h17;
      7: i[6:0] = 7'h6F;
      8: begin
        i[14:12] = 3'd0;
        i[6:0]   = 7'h67;
      end
      default: i[6:0] = b ? 7'h0F : 7'h73;
    endcase
    if ($urandom_range(0, 7) == 0) i[19:15] = 5'd0;
    if ($urandom_range(0, 7) == 0) i[24:20] = 5'd0;
    fe.if_inst   = i;
    fe.if_pc     = 32'h1000 + ($urandom_range(0, 127) << 2);
    fe.if_valid  = $urandom_range(0, 9) < 8;
    rs1_val      = $urandom;
    rs2_val      = $urandom;
    rs1_busy     = $urandom_range(0, 3) == 0;
    rs2_busy     = $urandom_range(0, 1) == 0;
    rs1_tag      = RW'($urandom);
    rs2_tag      = RW'($urandom);
    rob_tail     = RW'($urandom);
    rob_full     = $urandom_range(0, 9) == 0;
    rs_full      = $urandom_range(0, 9) == 0;
    lsb_full     = $urandom_range(0, 9) == 0;
    flush        = $urandom_range(0, 14) == 0;
    rdy          = $urandom_range(0, 9) != 0;
    rst_n        = $urandom_range(0, 60) != 0;
    bp_upd_valid = $urandom_range(0, 1) == 0;
    bp_upd_taken = $urandom_range(0, 1) == 0;
    bp_upd_pc    = 32'h1000 + ($urandom_range(0, 127) << 2);
  endtask

  initial begin
    e = '{default: 0};
    rst_n = 1'b0; rdy = 1'b1; flush = 1'b0;
    fe.if_valid = 1'b0; fe.if_pc = '0; fe.if_inst = 32'h00000013;
    rs1_val = '0; rs2_val = '0; rs1_busy = 1'b0; rs2_busy = 1'b0;
    rs1_tag = '0; rs2_tag = '0; rob_tail = '0;
    rob_full = 1'b0; rs_full = 1'b0; lsb_full = 1'b0;
    bp_upd_valid = 1'b0; bp_upd_taken = 1'b0; bp_upd_pc = '0;
    tick();
    tick();
    check("rst_op1_val", op1_val, 32'd0);
    check("rst_op2_val", op2_val, 32'd0);
    check("rst_redirect_pc", redirect_pc, 32'd0);
    check("rst_rob_imm", rob_imm, 32'd0);
    check("rst_lsb_offset", lsb_offset, 32'd0);
    rst_n = 1'b1;

    // ADDI x5,x0,-1 with a busy (but ignored) x0
    fe.if_valid = 1'b1; fe.if_pc = 32'h100; fe.if_inst = 32'hFFF00293;
    rs1_busy = 1'b1; rob_tail = 4'd7;
    tick();
    check("addi_rs_valid", rs_valid, 1'b1);
    check("addi_op2", op2_val, 32'hFFFFFFFF);
    check("addi_op1_busy", op1_busy, 1'b0);
    check("addi_dst_tag", dst_tag, 32'd7);
    check("addi_alt_pc", rob_alt_pc, 32'h104);

    // JALR x1,8(x2) stalled on a renamed x2
    fe.if_pc = 32'h200; fe.if_inst = 32'h008100E7; rs1_tag = 4'd3;
    repeat (3) begin
      tick();
      check("jalr_stall_ready", fe.if_ready, 1'b0);
    end
    rs1_busy = 1'b0; rs1_val = 32'h2001;
    tick();
    check("jalr_redirect_valid", redirect_valid, 1'b1);
    check("jalr_redirect_pc", redirect_pc, 32'h2008);
    check("jalr_rob_imm", rob_imm, 32'h204);
    check("jalr_rob_done", rob_done, 1'b1);

    // SW x3,4(x2) behind a full LSB
    fe.if_pc = 32'h300; fe.if_inst = 32'h00312223; lsb_full = 1'b1;
    repeat (2) begin
      tick();
      check("sw_full_rob_valid", rob_valid, 1'b0);
    end
    lsb_full = 1'b0;
    tick();
    check("sw_lsb_valid", lsb_valid, 1'b1);
    check("sw_lsb_type", lsb_type, 4'b0101);
    check("sw_rob_type", rob_type, 2'd2);

    // BEQ +16 at 0x40 after two not-taken updates to its counter
    fe.if_valid = 1'b0;
    bp_upd_valid = 1'b1; bp_upd_taken = 1'b0; bp_upd_pc = 32'h40;
    tick();
    tick();
    bp_upd_valid = 1'b0;
    fe.if_valid = 1'b1; fe.if_pc = 32'h40; fe.if_inst = 32'h00000863;
    tick();
`ifdef DEC_BPRED_EN
    check("beq_pred", rob_pred_taken, 1'b0);
    check("beq_redirect_valid", redirect_valid, 1'b0);
    check("beq_alt_pc", rob_alt_pc, 32'h50);
`else
    check("beq_redirect_valid", redirect_valid, 1'b1);
    check("beq_redirect_pc", redirect_pc, 32'h50);
`endif

    // flush wins over a valid JAL
    fe.if_pc = 32'h500; fe.if_inst = 32'h008000EF; flush = 1'b1;
    tick();
    check("flush_ready", fe.if_ready, 1'b0);
    check("flush_redirect", redirect_valid, 1'b0);
    check("flush_rob_valid", rob_valid, 1'b0);
    flush = 1'b0;

    // reset in the middle of dispatch, then the exit instruction
    fe.if_inst = 32'h002081B3; rs1_val = 32'h11; rs2_val = 32'h22;
    tick();
    rst_n = 1'b0;
    tick();
    check("rst_mid_rs_valid", rs_valid, 1'b0);
    check("rst_mid_op1_val", op1_val, 32'd0);
    check("rst_mid_rob_pc", rob_pc, 32'd0);
    rst_n = 1'b1;
    fe.if_inst = 32'hFF9FF06F;
    tick();
    check("exit_rob_type", rob_type, 2'd3);
    check("exit_redirect", redirect_valid, 1'b0);
    fe.if_valid = 1'b0;
    tick();

    repeat (800) begin
      rand_inputs();
      tick();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
